// File: rtl/spi_slave.sv
// SPI slave receiver: synchronizes sclk/cs/mosi into clk, captures LSB-first frames of DATA_W
// bits and hands them out on a valid/ready port with overrun and framing-error pulses.
`timescale 1ns/1ps

module spi_slave #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StWaitCs} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   armed_q, armed_d;
    logic                   err_seen_q, err_seen_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic              sclk_s, cs_s, mosi_s, sclk_rise, deliver;
    logic [DATA_W-1:0] frame;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};

        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_prev_q;
        frame     = shift_q | (DATA_W'(mosi_s) << count_q);

        sclk_prev_d = sclk_s;
        // The reset value of the cs synchronizer is not a real observation of cs high, so only
        // arm once the chain holds sampled data and that data shows cs deasserted.
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        err_seen_d  = err_seen_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            StIdle: begin
                if (armed_q && !cs_s) begin
                    state_d = StShift;
                    count_d = '0;
                    shift_d = '0;
                end
            end
            StShift: begin
                if (cs_s) begin
                    state_d     = StIdle;
                    frame_err_d = (count_q != '0);
                    count_d     = '0;
                    shift_d     = '0;
                end else if (sclk_rise) begin
                    shift_d = frame;
                    if (count_q == LastCnt) begin
                        state_d    = StWaitCs;
                        deliver    = 1'b1;
                        err_seen_d = 1'b0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StWaitCs: begin
                if (cs_s) begin
                    state_d = StIdle;
                end else if (sclk_rise && !err_seen_q) begin
                    frame_err_d = 1'b1;
                    err_seen_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (deliver) begin
            if (!valid_q || dout_ready) begin
                dout_d  = frame;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            err_seen_q  <= 1'b0;
            count_q     <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            err_seen_q  <= err_seen_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed and table-driven bench for spi_slave: SPI master model, pulse monitors and a small
// valid/ready scoreboard for the randomized back-to-back frames.
`timescale 1ns/1ps

module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        dout_ready;
    logic [11:0] dout;
    logic        dout_valid;
    logic        overrun;
    logic        frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    int wide_cnt = 0;
    logic ovr_prev = 1'b0;
    logic ferr_prev = 1'b0;

    spi_slave #(
        .DATA_W     (12),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (frame_err) ferr_cnt++;
        if ((overrun && ovr_prev) || (frame_err && ferr_prev)) wide_cnt++;
        ovr_prev  = overrun;
        ferr_prev = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sclk pulses only, 10 clk low then 10 clk high per bit; optional latency probe on last bit.
    task automatic clock_bits(input logic [15:0] data, input int nbits, input bit chk);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[i];
            sclk = 1'b0;
            repeat (10) @(negedge clk);
            sclk = 1'b1;
            if (chk && i == nbits - 1) begin
                repeat (2) @(negedge clk);
                check("lat_edge2_valid", 32'(dout_valid), 32'd0);
                @(negedge clk);
                check("lat_edge3_valid", 32'(dout_valid), 32'd1);
                check("lat_edge3_dout", 32'(dout), 32'h0A5C);
                @(negedge clk);
                check("lat_edge4_valid", 32'(dout_valid), 32'd0);
                repeat (6) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
        end
        sclk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits, input bit chk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
        clock_bits(data, nbits, chk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] data;
        int          nbits;
        logic        ready;
        logic [11:0] exp_dout;
        logic        exp_valid;
        int          exp_ovr;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [11:0] m_dout;
        logic        m_valid;
        int          drops;
        int          ovr0;
        int          ferr0;
        logic [11:0] rdata;
        logic        rready;

        vecs[0]  = '{16'h0123, 12, 1'b0, 12'h123, 1'b1, 0, 0};
        vecs[1]  = '{16'h0456, 12, 1'b0, 12'h123, 1'b1, 1, 0};
        vecs[2]  = '{16'h0000, 0,  1'b1, 12'h123, 1'b0, 0, 0};
        vecs[3]  = '{16'h0FFF, 7,  1'b0, 12'h123, 1'b0, 0, 1};
        vecs[4]  = '{16'h00F0, 12, 1'b0, 12'h0F0, 1'b1, 0, 0};
        vecs[5]  = '{16'h13C3, 13, 1'b1, 12'h3C3, 1'b0, 0, 1};
        vecs[6]  = '{16'h3ABC, 14, 1'b1, 12'hABC, 1'b0, 0, 1};
        vecs[7]  = '{16'h0555, 12, 1'b1, 12'h555, 1'b0, 0, 0};
        vecs[8]  = '{16'h0000, 12, 1'b0, 12'h000, 1'b1, 0, 0};
        vecs[9]  = '{16'h0FFF, 11, 1'b0, 12'h000, 1'b1, 0, 1};
        vecs[10] = '{16'h0FFF, 12, 1'b0, 12'h000, 1'b1, 1, 0};
        vecs[11] = '{16'h0FFF, 1,  1'b1, 12'h000, 1'b0, 0, 1};
        vecs[12] = '{16'h07E7, 12, 1'b0, 12'h7E7, 1'b1, 0, 0};

        rst        = 1'b0;
        sclk       = 1'b0;
        cs         = 1'b1;
        mosi       = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame with ready high: latency and one-cycle valid pulse.
        dout_ready = 1'b1;
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
        send_frame(16'h0A5C, 12, 1'b1);
        check("a5c_dout", 32'(dout), 32'h0A5C);
        check("a5c_ferr", 32'(ferr_cnt - ferr0), 32'd0);
        check("a5c_ovr", 32'(ovr_cnt - ovr0), 32'd0);

        foreach (vecs[k]) begin
            dout_ready = vecs[k].ready;
            ovr0  = ovr_cnt;
            ferr0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].nbits, 1'b0);
            check($sformatf("vec%0d_dout", k), 32'(dout), 32'(vecs[k].exp_dout));
            check($sformatf("vec%0d_valid", k), 32'(dout_valid), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_ovr", k), 32'(ovr_cnt - ovr0), 32'(vecs[k].exp_ovr));
            check($sformatf("vec%0d_ferr", k), 32'(ferr_cnt - ferr0), 32'(vecs[k].exp_ferr));
        end

        // Reset mid-frame, release with cs still low: stray sclk edges must be ignored.
        dout_ready = 1'b1;
        ferr0 = ferr_cnt;
        cs = 1'b0;
        repeat (10) @(negedge clk);
        clock_bits(16'h0FFF, 6, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_dout", 32'(dout), 32'h0);
        check("midrst_valid", 32'(dout_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clock_bits(16'h0FFF, 3, 1'b0);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_ferr", 32'(ferr_cnt - ferr0), 32'd0);
        check("midrst_ignored_valid", 32'(dout_valid), 32'd0);
        send_frame(16'h0801, 12, 1'b0);
        check("post_rst_dout", 32'(dout), 32'h801);
        check("post_rst_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        // Random back-to-back frames against a valid/ready scoreboard.
        m_dout  = 12'h801;
        m_valid = 1'b0;
        drops   = 0;
        ovr0    = ovr_cnt;
        for (int n = 0; n < 20; n++) begin
            rdata  = 12'($urandom);
            rready = 1'($urandom_range(0, 1));
            dout_ready = rready;
            send_frame({4'h0, rdata}, 12, 1'b0);
            if (!m_valid || rready) begin
                m_dout  = rdata;
                m_valid = 1'b1;
            end else begin
                drops++;
            end
            if (rready) m_valid = 1'b0;
            check($sformatf("rnd%0d_dout", n), 32'(dout), 32'(m_dout));
            check($sformatf("rnd%0d_valid", n), 32'(dout_valid), 32'(m_valid));
        end
        check("rnd_overrun_count", 32'(ovr_cnt - ovr0), 32'(drops));
        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
